// File: rtl/lsu_pkg.sv
// Shared types and constants for the byte-serial load/store unit.
package lsu_pkg;

  localparam int XLEN      = 64;
  localparam int BYTE_SIZE = 8;
  localparam int MAX_BYTES = XLEN / BYTE_SIZE;
  localparam int CNT_W     = $clog2(MAX_BYTES);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DRAIN,
    RESP
  } lsu_state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_MISALIGN = 2'd1,
    ERR_ILLEGAL  = 2'd2
  } lsu_err_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  // Beats per access for a funct3 size code (1, 2, 4 or 8).
  function automatic logic [CNT_W:0] size_to_bytes(input logic [1:0] size);
    return {{CNT_W{1'b0}}, 1'b1} << size;
  endfunction

endpackage

// File: rtl/lsu_byte_sequencer_if.sv
// Request/response handshake plus byte-wide memory port of the load/store unit.
// Handshakes: a transfer happens on a rising clk edge where valid and ready are
// both high; the producer holds its payload stable while valid is high.
interface lsu_byte_sequencer_if;

  logic                         req_valid;
  logic                         req_ready;
  logic                         req_store;
  logic [2:0]                   req_funct3;
  logic [lsu_pkg::XLEN-1:0]     req_addr;
  logic [lsu_pkg::XLEN-1:0]     req_wdata;

  logic                         resp_valid;
  logic                         resp_ready;
  logic [lsu_pkg::XLEN-1:0]     resp_rdata;
  logic [1:0]                   resp_err;

  logic                         mem_en;
  logic                         mem_we;
  logic [lsu_pkg::XLEN-1:0]     mem_addr;
  logic [lsu_pkg::BYTE_SIZE-1:0] mem_wbyte;
  logic [lsu_pkg::BYTE_SIZE-1:0] mem_rbyte;

  // Execute stage and data memory side.
  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata,
    output resp_ready, mem_rbyte,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_en, mem_we, mem_addr, mem_wbyte
  );

  // Sequencer side.
  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata,
    input  resp_ready, mem_rbyte,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_en, mem_we, mem_addr, mem_wbyte
  );

endinterface

// File: rtl/lsu_load_extend.sv
// Sign/zero extension of assembled load data; shared with the cache fill path.
module lsu_load_extend
  import lsu_pkg::*;
(
  input  logic [XLEN-1:0] data,
  input  logic [1:0]      size,
  input  logic            uns,
  output logic [XLEN-1:0] rdata
);

  always_comb begin
    rdata = data;
    case (size)
      SZ_B:    rdata = {{(XLEN-8){~uns & data[7]}},   data[7:0]};
      SZ_H:    rdata = {{(XLEN-16){~uns & data[15]}}, data[15:0]};
      SZ_W:    rdata = {{(XLEN-32){~uns & data[31]}}, data[31:0]};
      default: rdata = data;
    endcase
  end

endmodule

// File: rtl/lsu_byte_sequencer.sv
// Load/store controller: checks a request, walks it over the byte port
// little-endian, assembles/extends load data and returns one response.
module lsu_byte_sequencer
  import lsu_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  lsu_byte_sequencer_if.slave bus,
  output lsu_state_t          fsm_state
);

  localparam logic [CNT_W:0] ONE = {{CNT_W{1'b0}}, 1'b1};

  lsu_state_t       state_q, state_d;
  logic             store_q, uns_q;
  logic [1:0]       size_q;
  logic [XLEN-1:0]  addr_q, wdata_q;
  logic [CNT_W-1:0] cnt_q, cap_idx_q;
  logic             rd_pend_q;
  logic [XLEN-1:0]  asm_q, asm_d, ext;
  logic [XLEN-1:0]  rdata_q;
  lsu_err_t         err_q;

  logic             accept, illegal, misalign, last;
  logic [CNT_W:0]   req_n, cur_n;

  always_comb begin
    accept   = bus.req_valid && (state_q == IDLE);
    req_n    = size_to_bytes(bus.req_funct3[1:0]);
    illegal  = bus.req_store ? bus.req_funct3[2] : (bus.req_funct3 == 3'b111);
    misalign = (bus.req_addr[CNT_W:0] & (req_n - ONE)) != '0;
    cur_n    = size_to_bytes(size_q);
    last     = ({1'b0, cnt_q} == (cur_n - ONE));
  end

  // Read byte lands one cycle after its beat; merge it into the lane it was issued for.
  always_comb begin
    asm_d = asm_q;
    for (int b = 0; b < MAX_BYTES; b++) begin
      if (rd_pend_q && (cap_idx_q == CNT_W'(b))) begin
        asm_d[b*BYTE_SIZE +: BYTE_SIZE] = bus.mem_rbyte;
      end
    end
  end

  lsu_load_extend u_extend (
    .data  (asm_d),
    .size  (size_q),
    .uns   (uns_q),
    .rdata (ext)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.mem_en     = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wbyte  = '0;
    case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (accept) state_d = (illegal || misalign) ? RESP : ACCESS;
      end
      ACCESS: begin
        bus.mem_en   = 1'b1;
        bus.mem_we   = store_q;
        bus.mem_addr = addr_q + {{(XLEN-CNT_W){1'b0}}, cnt_q};
        for (int b = 0; b < MAX_BYTES; b++) begin
          if (cnt_q == CNT_W'(b)) bus.mem_wbyte = wdata_q[b*BYTE_SIZE +: BYTE_SIZE];
        end
        if (last) state_d = store_q ? RESP : DRAIN;
      end
      DRAIN: state_d = RESP;
      RESP: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      store_q   <= 1'b0;
      uns_q     <= 1'b0;
      size_q    <= SZ_B;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      cap_idx_q <= '0;
      rd_pend_q <= 1'b0;
      asm_q     <= '0;
      rdata_q   <= '0;
      err_q     <= ERR_NONE;
    end else begin
      rd_pend_q <= (state_q == ACCESS) && !store_q;
      cap_idx_q <= cnt_q;
      asm_q     <= asm_d;
      case (state_q)
        IDLE: begin
          if (accept) begin
            store_q <= bus.req_store;
            uns_q   <= bus.req_funct3[2];
            size_q  <= bus.req_funct3[1:0];
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            cnt_q   <= '0;
            asm_q   <= '0;
            rdata_q <= '0;
            err_q   <= illegal ? ERR_ILLEGAL : (misalign ? ERR_MISALIGN : ERR_NONE);
          end
        end
        ACCESS:  cnt_q <= cnt_q + CNT_W'(1);
        // The final byte is still in flight here, so extend the merged view.
        DRAIN:   rdata_q <= ext;
        default: ;
      endcase
    end
  end

  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  assign fsm_state      = state_q;

endmodule

// File: tb/tb_lsu_byte_sequencer.sv
// Directed bench for lsu_byte_sequencer with a byte-wide memory model.
module tb_lsu_byte_sequencer;
  import lsu_pkg::*;

  logic       clk;
  logic       rst;
  lsu_state_t fsm_state;

  lsu_byte_sequencer_if bus();

  lsu_byte_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int beat_total = 0;
  logic [71:0] exp_q[$];
  logic [7:0]  mem [256];

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // memory model: preload on reset, registered read
  always @(posedge clk) begin
    if (rst) begin
      mem[8'h21] <= 8'h80;
      mem[8'h40] <= 8'h78; mem[8'h41] <= 8'h56; mem[8'h42] <= 8'h34; mem[8'h43] <= 8'h12;
      mem[8'h44] <= 8'hEF; mem[8'h45] <= 8'hBE; mem[8'h46] <= 8'hAD; mem[8'h47] <= 8'hDE;
      mem[8'h50] <= 8'hFF; mem[8'h51] <= 8'h7F;
    end else if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr[7:0]] <= bus.mem_wbyte;
      else            bus.mem_rbyte <= mem[bus.mem_addr[7:0]];
    end
  end

  // scoreboard for write beats
  always @(negedge clk) begin
    if (bus.mem_en) begin
      beat_total++;
      if (bus.mem_we) begin
        if (exp_q.size() == 0) check("wr_unexpected", exp_q.size(), 1);
        else                   check("wr_beat", {bus.mem_addr, bus.mem_wbyte}, exp_q.pop_front());
      end
    end
  end

  task automatic drive_garbage();
    bus.req_store  = 1'($urandom_range(0, 1));
    bus.req_funct3 = 3'($urandom_range(0, 7));
    bus.req_addr   = {$urandom, $urandom};
    bus.req_wdata  = {$urandom, $urandom};
  endtask

  task automatic issue(input logic st, input logic [2:0] f3, input logic [63:0] addr,
                       input logic [63:0] wdata, input string tag);
    int k;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_store  = st;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    k = 0;
    while (!bus.req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_accept"}, bus.req_ready, 1'b1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    drive_garbage();
  endtask

  task automatic run_req(input string tag, input logic st, input logic [2:0] f3,
                         input logic [63:0] addr, input logic [63:0] wdata,
                         input int exp_lat, input logic [63:0] exp_rdata,
                         input logic [1:0] exp_err, input int exp_beats, input int hold);
    int lat;
    int base;
    logic [63:0] rd0;
    issue(st, f3, addr, wdata, tag);
    base = beat_total;
    lat  = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.resp_valid && lat < 40);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_rdata"}, bus.resp_rdata, exp_rdata);
    check({tag, "_err"}, bus.resp_err, exp_err);
    rd0 = bus.resp_rdata;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, bus.resp_valid, 1'b1);
      check({tag, "_hold_rdata"}, bus.resp_rdata, rd0);
      check({tag, "_hold_ready"}, bus.req_ready, 1'b0);
    end
    @(negedge clk);
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
    check({tag, "_beats"}, beat_total - base, exp_beats);
    check({tag, "_done_valid"}, bus.resp_valid, 1'b0);
    check({tag, "_done_ready"}, bus.req_ready, 1'b1);
  endtask

  initial begin
    int k;
    int base;
    logic [7:0] st_d_bytes [8];
    st_d_bytes = '{8'h88, 8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11};

    rst = 1'b1;
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b0;
    drive_garbage();
    repeat (3) @(negedge clk);
    check("rst_req_ready", bus.req_ready, 1'b1);
    check("rst_resp_valid", bus.resp_valid, 1'b0);
    check("rst_resp_rdata", bus.resp_rdata, 64'h0);
    check("rst_resp_err", bus.resp_err, 2'd0);
    check("rst_mem_en", bus.mem_en, 1'b0);
    check("rst_mem_we", bus.mem_we, 1'b0);
    check("rst_mem_addr", bus.mem_addr, 64'h0);
    check("rst_mem_wbyte", bus.mem_wbyte, 8'h0);
    check("rst_state", fsm_state, IDLE);
    rst = 1'b0;

    // D store then read back
    for (int i = 0; i < 8; i++) exp_q.push_back({64'h10 + 64'(i), st_d_bytes[i]});
    run_req("st_d", 1'b1, 3'b011, 64'h10, 64'h1122334455667788, 9, 64'h0, 2'd0, 8, 0);
    check("st_d_q_empty", exp_q.size(), 0);
    run_req("ld_d", 1'b0, 3'b011, 64'h10, 64'h0, 10, 64'h1122334455667788, 2'd0, 8, 0);

    // byte loads, signed and unsigned
    run_req("ld_b", 1'b0, 3'b000, 64'h21, 64'h0, 3, 64'hFFFFFFFFFFFFFF80, 2'd0, 1, 0);
    run_req("ld_bu", 1'b0, 3'b100, 64'h21, 64'h0, 3, 64'h0000000000000080, 2'd0, 1, 0);

    // errors: misaligned, illegal, illegal beats misaligned
    run_req("ld_w_mis", 1'b0, 3'b010, 64'h32, 64'h0, 1, 64'h0, 2'd1, 0, 0);
    run_req("st_ill", 1'b1, 3'b101, 64'h40, 64'hFFFF, 1, 64'h0, 2'd2, 0, 0);
    run_req("ld_ill_prio", 1'b0, 3'b111, 64'h33, 64'h0, 1, 64'h0, 2'd2, 0, 0);

    // word loads with bit 31 set
    run_req("ld_w", 1'b0, 3'b010, 64'h44, 64'h0, 6, 64'hFFFFFFFFDEADBEEF, 2'd0, 4, 0);
    run_req("ld_wu", 1'b0, 3'b110, 64'h44, 64'h0, 6, 64'h00000000DEADBEEF, 2'd0, 4, 0);

    // H store uses only the low bytes of wdata
    exp_q.push_back({64'h72, 8'hEF});
    exp_q.push_back({64'h73, 8'hBE});
    run_req("st_h", 1'b1, 3'b001, 64'h72, 64'hFFFF_FFFF_FFFF_BEEF, 3, 64'h0, 2'd0, 2, 0);
    check("st_h_q_empty", exp_q.size(), 0);

    // backpressure on an H load
    run_req("ld_h_bp", 1'b0, 3'b001, 64'h50, 64'h0, 4, 64'h7FFF, 2'd0, 2, 5);

    // reset during the fourth beat of a D store
    exp_q.push_back({64'h60, 8'hA8});
    exp_q.push_back({64'h61, 8'hA7});
    exp_q.push_back({64'h62, 8'hA6});
    exp_q.push_back({64'h63, 8'hA5});
    issue(1'b1, 3'b011, 64'h60, 64'hA1A2A3A4A5A6A7A8, "st_rst");
    base = beat_total;
    k = 0;
    while ((beat_total - base) < 4 && k < 20) begin
      @(negedge clk);
      #2;
      k++;
    end
    check("st_rst_beats", beat_total - base, 4);
    rst = 1'b1;
    #1;
    check("st_rst_mem_en", bus.mem_en, 1'b0);
    check("st_rst_state", fsm_state, IDLE);
    check("st_rst_resp_valid", bus.resp_valid, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("st_rst_ready", bus.req_ready, 1'b1);
    check("st_rst_no_resp", bus.resp_valid, 1'b0);
    check("st_rst_q_empty", exp_q.size(), 0);
    run_req("ld_w_post", 1'b0, 3'b010, 64'h40, 64'h0, 6, 64'h0000000012345678, 2'd0, 4, 0);

    // report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
